// File: rtl/beat_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beat_pkg
// Purpose  : Shared constants and helpers for the beat generator slice.
//            DEFAULT_PERIOD_32 - reset beat period (clocks)
//            DEFAULT_BAR_LEN   - beats per bar
//            clamp_period()    - maps a requested period of 0 to 1
// Revision : 1.0 - initial release
// ============================================================================
package beat_pkg;

    localparam int DEFAULT_PERIOD_32 = 32;
    localparam int DEFAULT_BAR_LEN   = 4;

    // Wide enough for any practical counter width; callers cast in and out.
    localparam int CLAMP_W = 64;

    // A zero period would never wrap, so it is treated as "every cycle".
    function automatic logic [CLAMP_W-1:0] clamp_period(input logic [CLAMP_W-1:0] p);
        return (p == '0) ? CLAMP_W'(1) : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beat_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : beat_gen_if
// Purpose  : Control/status bundle of the beat generator.
//            master : drives enable, period, period_load, restart
//                     and observes beat, bar, beat_idx, phase
//            slave  : the generator side (mirror directions)
// Revision : 1.0 - initial release
// ============================================================================
interface beat_gen_if
    import beat_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int BAR_LEN = DEFAULT_BAR_LEN
);
    logic                       enable;
    logic [WIDTH-1:0]           period;
    logic                       period_load;
    logic                       restart;
    logic                       beat;
    logic                       bar;
    logic [$clog2(BAR_LEN)-1:0] beat_idx;
    logic [WIDTH-1:0]           phase;

    modport master (
        output enable, period, period_load, restart,
        input  beat, bar, beat_idx, phase
    );

    modport slave (
        input  enable, period, period_load, restart,
        output beat, bar, beat_idx, phase
    );
endinterface
`default_nettype wire

// File: rtl/beat_gen_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Counter 0..last with enable, synchronous clear and runtime
//            terminal value. wrap is high in the enabled cycle whose edge
//            returns the count to 0.
//   clock  : rising-edge clock
//   reset  : synchronous, active-low
//   en     : advance one step
//   clr    : synchronous clear (wins over en)
//   last   : terminal count (modulus - 1)
//   count  : registered count
//   wrap   : combinational wrap indicator
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic [WIDTH-1:0] last,
    output logic      [WIDTH-1:0] count,
    output logic                  wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // >= rather than == keeps the counter bounded should last ever drop
        // below the current count.
        wrap    = en && (count_q >= last);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/beat_gen.sv
`default_nettype none
// ============================================================================
// Module   : beat_gen
// Purpose  : Tempo/beat generator. Emits a one-cycle beat every P enabled
//            clocks and a bar pulse on each downbeat of a BAR_LEN-beat bar.
//            P can be reprogrammed at run time; the change lands on the next
//            beat boundary so the beat in progress is never cut short.
//   clock  : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : beat_gen_if slave (enable, period, period_load, restart in;
//            beat, bar, beat_idx, phase out - all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module beat_gen
    import beat_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BAR_LEN        = DEFAULT_BAR_LEN,
    parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_32
) (
    input  wire logic clock,
    input  wire logic reset,
    beat_gen_if.slave bus
);

    localparam int IDX_W = $clog2(BAR_LEN);

    logic [WIDTH-1:0] p_q,    p_d;      // active period
    logic [WIDTH-1:0] pn_q,   pn_d;     // pending period
    logic             pv_q,   pv_d;     // pending valid
    logic             beat_q, beat_d;
    logic             bar_q,  bar_d;

    logic [WIDTH-1:0] w_period_clamped;
    logic [WIDTH-1:0] w_phase_last;
    logic [WIDTH-1:0] w_phase;
    logic             w_phase_wrap;
    logic [IDX_W-1:0] w_idx;
    logic             w_idx_wrap;
    logic             w_wrap_ev;

    assign w_period_clamped = WIDTH'(clamp_period(CLAMP_W'(bus.period)));
    assign w_phase_last     = p_q - WIDTH'(1);

    // Restart overrides a coincident wrap: no pulse, no bar advance.
    assign w_wrap_ev = w_phase_wrap && !bus.restart;

    mod_counter #(
        .WIDTH (WIDTH)
    ) u_phase_ctr (
        .clock (clock),
        .reset (reset),
        .en    (bus.enable),
        .clr   (bus.restart),
        .last  (w_phase_last),
        .count (w_phase),
        .wrap  (w_phase_wrap)
    );

    mod_counter #(
        .WIDTH (IDX_W)
    ) u_idx_ctr (
        .clock (clock),
        .reset (reset),
        .en    (w_wrap_ev),
        .clr   (bus.restart),
        .last  (IDX_W'(BAR_LEN - 1)),
        .count (w_idx),
        .wrap  (w_idx_wrap)
    );

    always_comb begin
        p_d    = p_q;
        pn_d   = pn_q;
        pv_d   = pv_q;
        beat_d = 1'b0;
        bar_d  = 1'b0;
        if (bus.restart) begin
            // A load in the restart cycle is newer than any pending value.
            if (bus.period_load) begin
                p_d  = w_period_clamped;
                pn_d = w_period_clamped;
                pv_d = 1'b0;
            end else if (pv_q) begin
                p_d  = pn_q;
                pv_d = 1'b0;
            end
        end else begin
            if (w_wrap_ev) begin
                beat_d = 1'b1;
                bar_d  = w_idx_wrap;
                if (pv_q) begin
                    p_d  = pn_q;
                    pv_d = 1'b0;
                end
            end
            // Applied after the wrap so a coincident load stays pending
            // for the following beat.
            if (bus.period_load) begin
                pn_d = w_period_clamped;
                pv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            p_q    <= WIDTH'(DEFAULT_PERIOD);
            pn_q   <= WIDTH'(DEFAULT_PERIOD);
            pv_q   <= 1'b0;
            beat_q <= 1'b0;
            bar_q  <= 1'b0;
        end else begin
            p_q    <= p_d;
            pn_q   <= pn_d;
            pv_q   <= pv_d;
            beat_q <= beat_d;
            bar_q  <= bar_d;
        end
    end

    assign bus.beat     = beat_q;
    assign bus.bar      = bar_q;
    assign bus.beat_idx = w_idx;
    assign bus.phase    = w_phase;

endmodule
`default_nettype wire

// File: doc/beat_gen.md
# beat_gen

Parametrised tempo/beat generator for the music-player datapath, generalising the fixed divide-by-32 beat counter. It emits a one-cycle `beat` pulse every `P` enabled clocks, where `P` can be changed at run time without glitching the current beat. It also tracks the position within a bar of `BAR_LEN` beats and pulses `bar` on each downbeat. Note players, sequencers and the tempo display consume it.

## Interface
- `WIDTH`, 16: width of the period and phase counters.
- `BAR_LEN`, 4: beats per bar; must be ≥ 2.
- `DEFAULT_PERIOD`, 32: period loaded at reset; must be ≥ 1 and < 2^WIDTH.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `enable` input 1: when high, counting advances one step per clock.
- `period` input WIDTH: new beat period, in clocks.
- `period_load` input 1: one-cycle strobe that captures `period` into the pending register.
- `restart` input 1: synchronous phase restart; clears the phase and beat index.
- `beat` output 1: registered pulse, one cycle wide.
- `bar` output 1: registered pulse, coincident with the `beat` that starts a new bar.
- `beat_idx` output `$clog2(BAR_LEN)`: index of the beat within the bar, range 0..BAR_LEN-1.
- `phase` output WIDTH: current position within the beat, range 0..P-1.

## Operation
- State:
  - active period `P`
  - pending period `Pn` with valid flag `pv`
  - phase counter
  - `beat_idx`
  - registered `beat`/`bar`
- Period clamp: a loaded value of 0 is stored as 1. With P=1, `beat` is high on every enabled cycle.
- Counting, when `enable`=1: `phase` increments. At `phase`=P-1 it wraps to 0, which is a wrap event.
- On each wrap event:
  - `beat`=1 next cycle.
  - `beat_idx` increments modulo BAR_LEN.
  - `bar`=1 next cycle iff `beat_idx` wraps from BAR_LEN-1 to 0.
- With `enable`=0:
  - `phase` and `beat_idx` hold.
  - `beat` and `bar` are 0 (pulses are never stretched).
  - `period_load` is still accepted.
- Period change:
  - `period_load` sets `Pn`←clamp(`period`) and `pv`←1.
  - At the next wrap event, P←`Pn` and `pv`←0. The beat in progress therefore completes at the old period.
  - A later `period_load` before the wrap overwrites `Pn`; last write wins.
  - `period_load` in the same cycle as a wrap: the wrap uses the old `Pn`/P state, and the new value becomes pending for the following wrap.
- `restart`:
  - Next cycle: `phase`=0 and `beat_idx`=0, with no `beat`/`bar` that cycle.
  - If `pv`=1, or if `period_load` is high in the same cycle, the new period takes effect immediately.
  - Works regardless of `enable`.
- Priority: `reset` > `restart` > wrap/period apply > count > hold.
- Reset values (`reset`=0 at an edge):
  - P=DEFAULT_PERIOD, `pv`=0, `phase`=0, `beat_idx`=0, `beat`=0, `bar`=0.
  - Reset asserted mid-beat discards the pending period.

## Timing
- Outputs are registered; there are no combinational input→output paths.
- First beat: with `enable` held high from the first clock after reset release, `beat` is high in the cycle after the P-th enabled edge. With the default, that is after edge 32. Beats then repeat every P enabled cycles.
- `phase`/`beat_idx` update on the same edge that produces the pulse. During a `beat` cycle, `phase`=0 and `beat_idx` is the new value.
- A period change becomes visible on the wrap edge. The first beat at the new period follows P_new enabled cycles after that edge.
- `restart` to first beat: P enabled edges, counted from the edge after `restart`.

## Structure
- Shared package `beat_pkg` holds:
  - `DEFAULT_PERIOD_32` (=32)
  - `DEFAULT_BAR_LEN` (=4)
  - the function `clamp_period` (0→1)
- One natural sub-module: `mod_counter`, a modulo-N counter with enable, sync clear, runtime modulus and a wrap output. It is instantiated twice: once for the phase (modulus P) and once for the beat index (modulus BAR_LEN, enabled by the phase wrap).
- Period/pending registers and output pulse registers live in `beat_gen`.

## Test plan
- **Reset and default period.** Stimulus: `reset` low for 2 cycles, then `enable`=1 constant. Required: `beat`=0 for the first 32 cycles, high for 1 cycle after edge 32, then every 32 cycles. `bar` accompanies the 4th beat.
- **Mid-beat period change.** Stimulus: at `phase`=10 under P=32, `period_load` with `period`=8. Required: the current beat still completes at 32, and subsequent beats arrive every 8 cycles. A second load of 5 before that wrap replaces 8.
- **Enable gating.** Stimulus: drop `enable` for 7 cycles at `phase`=20. Required: `phase` holds at 20, no pulses, and the next beat is delayed by exactly 7 cycles.
- **Restart with load.** Stimulus: `restart`+`period_load` (`period`=3) at `phase`=15, `beat_idx`=2. Required: the next cycle shows `phase`=0 and `beat_idx`=0, and beats then arrive every 3 cycles. `bar` occurs on the 4th beat after restart.
- **Period clamp.** Stimulus: load `period`=0 or `period`=1. Required: `beat` high on every enabled cycle, with `bar` every 4th cycle.
- **Reset mid-operation.** Stimulus: pending load of 12, then `reset` low for 1 cycle. Required: all outputs are 0 and P=32, with the first beat 32 enabled cycles after release; the value 12 is never applied.
